// File: rtl/cpu_pkg.sv
// Shared definitions for the control unit and ALU: opcodes, FSM states,
// instruction field positions, flag indices and the decoded-instruction record.
package cpu_pkg;

    localparam logic [4:0] OP_LDR  = 5'b00000;
    localparam logic [4:0] OP_STR  = 5'b00001;
    localparam logic [4:0] OP_ADD  = 5'b00010;
    localparam logic [4:0] OP_SUB  = 5'b00011;
    localparam logic [4:0] OP_MOV  = 5'b00100;
    localparam logic [4:0] OP_CMP  = 5'b00101;
    localparam logic [4:0] OP_AND  = 5'b01000;
    localparam logic [4:0] OP_ORR  = 5'b01001;
    localparam logic [4:0] OP_EOR  = 5'b01010;
    localparam logic [4:0] OP_MVN  = 5'b01011;
    localparam logic [4:0] OP_LSL  = 5'b01100;
    localparam logic [4:0] OP_LSR  = 5'b01101;
    localparam logic [4:0] OP_MUL  = 5'b10000;
    localparam logic [4:0] OP_B    = 5'b10001;
    localparam logic [4:0] OP_BEQ  = 5'b10010;
    localparam logic [4:0] OP_BNE  = 5'b10011;
    localparam logic [4:0] OP_BGT  = 5'b10100;
    localparam logic [4:0] OP_BLT  = 5'b10101;
    localparam logic [4:0] OP_HALT = 5'b11111;

    localparam int OPC_MSB  = 31;
    localparam int OPC_LSB  = 27;
    localparam int MODE_BIT = 26;
    localparam int RD_MSB   = 25;
    localparam int RD_LSB   = 23;
    localparam int RN_MSB   = 22;
    localparam int RN_LSB   = 20;
    localparam int IMM_MSB  = 19;
    localparam int IMM_LSB  = 0;

    localparam int FLAG_GT = 3;
    localparam int FLAG_LT = 2;
    localparam int FLAG_NE = 1;
    localparam int FLAG_EQ = 0;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    typedef struct packed {
        logic [4:0]  opcode;
        logic [4:0]  alu_opcode;
        logic        mode;
        logic [2:0]  rd;
        logic [2:0]  ra;
        logic [2:0]  rb;
        logic [19:0] imm;
        logic        is_mem;
        logic        is_store;
        logic        is_branch;
        logic        is_cmp;
        logic        is_wb;
        logic        is_halt;
        logic        is_illegal;
    } decoded_t;

    // Conditional branches look only at the flags left by the last CMP.
    function automatic logic branch_taken(input logic [4:0] opcode, input logic [3:0] flags);
        case (opcode)
            OP_B:    return 1'b1;
            OP_BEQ:  return flags[FLAG_EQ];
            OP_BNE:  return flags[FLAG_NE];
            OP_BGT:  return flags[FLAG_GT];
            OP_BLT:  return flags[FLAG_LT];
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/control_unit_if.sv
// Bus bundle between the control unit and instruction memory, data memory,
// register file and ALU. master = control unit, slave = surrounding datapath.
interface control_unit_if #(
    parameter int PC_WIDTH = 20
);
    logic                imem_req;
    logic [PC_WIDTH-1:0] imem_addr;
    logic                imem_valid;
    logic [31:0]         imem_rdata;

    logic [2:0]          ra_addr;
    logic [2:0]          rb_addr;
    logic [31:0]         reg_a_data;

    logic [4:0]          alu_opcode;
    logic                alu_addressing_mode;
    logic [19:0]         alu_immediate;
    logic [31:0]         alu_result;
    logic [3:0]          alu_cmp;

    logic                dmem_req;
    logic                dmem_we;
    logic [31:0]         dmem_addr;
    logic [31:0]         dmem_wdata;
    logic                dmem_ack;
    logic [31:0]         dmem_rdata;

    logic                rf_we;
    logic [2:0]          rf_waddr;
    logic [31:0]         rf_wdata;

    modport master (
        output imem_req, imem_addr, ra_addr, rb_addr,
        output alu_opcode, alu_addressing_mode, alu_immediate,
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output rf_we, rf_waddr, rf_wdata,
        input  imem_valid, imem_rdata, reg_a_data, alu_result, alu_cmp,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  imem_req, imem_addr, ra_addr, rb_addr,
        input  alu_opcode, alu_addressing_mode, alu_immediate,
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  rf_we, rf_waddr, rf_wdata,
        output imem_valid, imem_rdata, reg_a_data, alu_result, alu_cmp,
        output dmem_ack, dmem_rdata
    );

endinterface

// File: rtl/instr_decoder.sv
// Combinational decode of the instruction register into ALU controls,
// register indices and instruction-class flags.
module instr_decoder
    import cpu_pkg::*;
(
    input  logic [31:0] ir,
    output decoded_t    dec
);

    logic [4:0]  opc;
    logic [2:0]  rd;
    logic [19:0] imm;

    assign opc = ir[OPC_MSB:OPC_LSB];
    assign rd  = ir[RD_MSB:RD_LSB];
    assign imm = ir[IMM_MSB:IMM_LSB];

    // CMP borrows SUB; branches and HALT keep the ALU on a harmless MOV.
    always_comb begin
        dec            = '0;
        dec.opcode     = opc;
        dec.alu_opcode = opc;
        dec.mode       = ir[MODE_BIT];
        dec.rd         = rd;
        dec.ra         = ir[RN_MSB:RN_LSB];
        dec.rb         = ir[MODE_BIT] ? imm[2:0] : 3'd0;
        dec.imm        = imm;
        case (opc)
            OP_LDR: dec.is_mem = 1'b1;
            OP_STR: begin
                dec.is_mem   = 1'b1;
                dec.is_store = 1'b1;
                dec.ra       = rd;
            end
            OP_ADD, OP_SUB, OP_MOV, OP_AND, OP_ORR, OP_EOR,
            OP_MVN, OP_LSL, OP_LSR, OP_MUL: dec.is_wb = 1'b1;
            OP_CMP: begin
                dec.is_cmp     = 1'b1;
                dec.alu_opcode = OP_SUB;
            end
            OP_B, OP_BEQ, OP_BNE, OP_BGT, OP_BLT: begin
                dec.is_branch  = 1'b1;
                dec.alu_opcode = OP_MOV;
            end
            OP_HALT: begin
                dec.is_halt    = 1'b1;
                dec.alu_opcode = OP_MOV;
            end
            default: dec.is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle fetch/decode/execute sequencer driving the ALU, memories and register file.
// Optional macro CU_INSTRET_COUNTER_EN adds a 32-bit retired-instruction counter port.
module control_unit
    import cpu_pkg::*;
#(
    parameter int                  PC_WIDTH = 20,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    control_unit_if.master      bus,
    output logic [PC_WIDTH-1:0] pc,
    output logic                halted,
    output logic                illegal
`ifdef CU_INSTRET_COUNTER_EN
    ,
    output logic [31:0]         instret
`endif
);

    state_t              state;
    logic [31:0]         ir;
    logic [3:0]          flags;
    decoded_t            dec;
    logic [PC_WIDTH-1:0] pc_inc;

    logic [2:0]          ra_q;
    logic [2:0]          rb_q;
    logic [4:0]          alu_op_q;
    logic                alu_mode_q;
    logic [19:0]         alu_imm_q;
    logic [31:0]         dmem_addr_q;
    logic [31:0]         dmem_wdata_q;
    logic [2:0]          rf_waddr_q;
    logic [31:0]         rf_wdata_q;
    logic                fetch_req;
    logic                mem_req;

    instr_decoder u_decoder (
        .ir  (ir),
        .dec (dec)
    );

    assign pc_inc = pc + PC_WIDTH'(1);

    // Requests are decoded from the state register but gated by rst so that
    // a reset drops them in the very cycle it is asserted.
    assign fetch_req = (state == S_FETCH) && !rst;
    assign mem_req   = (state == S_MEM) && !rst;

    assign bus.imem_req            = fetch_req;
    assign bus.imem_addr           = pc;
    assign bus.dmem_req            = mem_req;
    assign bus.dmem_we             = mem_req && dec.is_store;
    assign bus.rf_we               = (state == S_WB) && !rst;
    assign bus.ra_addr             = ra_q;
    assign bus.rb_addr             = rb_q;
    assign bus.alu_opcode          = alu_op_q;
    assign bus.alu_addressing_mode = alu_mode_q;
    assign bus.alu_immediate       = alu_imm_q;
    assign bus.dmem_addr           = dmem_addr_q;
    assign bus.dmem_wdata          = dmem_wdata_q;
    assign bus.rf_waddr            = rf_waddr_q;
    assign bus.rf_wdata            = rf_wdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_FETCH;
            pc           <= RESET_PC;
            ir           <= '0;
            flags        <= '0;
            halted       <= 1'b0;
            illegal      <= 1'b0;
            ra_q         <= '0;
            rb_q         <= '0;
            alu_op_q     <= '0;
            alu_mode_q   <= 1'b0;
            alu_imm_q    <= '0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
            rf_waddr_q   <= '0;
            rf_wdata_q   <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (bus.imem_valid) begin
                        ir    <= bus.imem_rdata;
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    ra_q       <= dec.ra;
                    rb_q       <= dec.rb;
                    alu_op_q   <= dec.alu_opcode;
                    alu_mode_q <= dec.mode;
                    alu_imm_q  <= dec.imm;
                    state      <= S_EXECUTE;
                end
                S_EXECUTE: begin
                    if (dec.is_illegal) begin
                        illegal <= 1'b1;
                        halted  <= 1'b1;
                        state   <= S_HALT;
                    end else if (dec.is_halt) begin
                        halted <= 1'b1;
                        state  <= S_HALT;
                    end else if (dec.is_mem) begin
                        dmem_addr_q  <= bus.alu_result;
                        dmem_wdata_q <= bus.reg_a_data;
                        state        <= S_MEM;
                    end else if (dec.is_cmp) begin
                        flags <= bus.alu_cmp;
                        pc    <= pc_inc;
                        state <= S_FETCH;
                    end else if (dec.is_branch) begin
                        pc    <= branch_taken(dec.opcode, flags) ? PC_WIDTH'(dec.imm) : pc_inc;
                        state <= S_FETCH;
                    end else if (dec.is_wb) begin
                        rf_waddr_q <= dec.rd;
                        rf_wdata_q <= bus.alu_result;
                        state      <= S_WB;
                    end else begin
                        illegal <= 1'b1;
                        halted  <= 1'b1;
                        state   <= S_HALT;
                    end
                end
                S_MEM: begin
                    if (bus.dmem_ack) begin
                        if (dec.is_store) begin
                            pc    <= pc_inc;
                            state <= S_FETCH;
                        end else begin
                            rf_waddr_q <= dec.rd;
                            rf_wdata_q <= bus.dmem_rdata;
                            state      <= S_WB;
                        end
                    end
                end
                S_WB: begin
                    pc    <= pc_inc;
                    state <= S_FETCH;
                end
                S_HALT: state <= S_HALT;
                default: state <= S_FETCH;
            endcase
        end
    end

`ifdef CU_INSTRET_COUNTER_EN
    logic retire;

    // An instruction retires on whichever transition hands control back to FETCH.
    assign retire = (state == S_WB)
                 || ((state == S_EXECUTE) && (dec.is_cmp || dec.is_branch))
                 || ((state == S_MEM) && bus.dmem_ack && dec.is_store);

    always_ff @(posedge clk) begin
        if (rst) begin
            instret <= '0;
        end else if (retire) begin
            instret <= instret + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: the bench plays memories, register file
// and ALU, and predicts every observable output from an instruction-level model.
module tb_control_unit;

    localparam int         PCW    = 20;
    localparam logic [19:0] RST_PC = 20'h0;

    localparam int K_ALU  = 0;
    localparam int K_LDR  = 1;
    localparam int K_STR  = 2;
    localparam int K_CMP  = 3;
    localparam int K_BR   = 4;
    localparam int K_HALT = 5;
    localparam int K_ILL  = 6;

    logic            clk = 1'b0;
    logic            rst;
    logic [PCW-1:0]  pc;
    logic            halted;
    logic            illegal;
`ifdef CU_INSTRET_COUNTER_EN
    logic [31:0]     instret;
`endif

    int              vectors     = 0;
    int              miscompares = 0;
    logic [PCW-1:0]  mPc;
    logic [3:0]      mFlags;
    logic [31:0]     mInstret;

    logic [4:0] legalOps [18] = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00101,
                                  5'b01000, 5'b01001, 5'b01010, 5'b01011, 5'b01100, 5'b01101,
                                  5'b10000, 5'b10001, 5'b10010, 5'b10011, 5'b10100, 5'b10101};
    logic [4:0] illegalOps [13] = '{5'b00110, 5'b00111, 5'b01110, 5'b01111, 5'b10110, 5'b10111,
                                    5'b11000, 5'b11001, 5'b11010, 5'b11011, 5'b11100, 5'b11101,
                                    5'b11110};

    control_unit_if #(.PC_WIDTH(PCW)) bus ();

    control_unit #(.PC_WIDTH(PCW), .RESET_PC(RST_PC)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .pc      (pc),
        .halted  (halted),
        .illegal (illegal)
`ifdef CU_INSTRET_COUNTER_EN
        ,
        .instret (instret)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic doReset();
        rst            = 1'b1;
        bus.imem_valid = 1'b0;
        bus.dmem_ack   = 1'b0;
        #1;
        checkOutput("rst_imem_req_drop", 32'(bus.imem_req), 32'd0);
        checkOutput("rst_dmem_req_drop", 32'(bus.dmem_req), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        mPc      = RST_PC;
        mFlags   = 4'd0;
        mInstret = 32'd0;
        checkOutput("rst_pc", 32'(pc), 32'(mPc));
        checkOutput("rst_halted", 32'(halted), 32'd0);
        checkOutput("rst_illegal", 32'(illegal), 32'd0);
        checkOutput("rst_rf_we", 32'(bus.rf_we), 32'd0);
        checkOutput("rst_dmem_we", 32'(bus.dmem_we), 32'd0);
        checkOutput("rst_alu_opcode", 32'(bus.alu_opcode), 32'd0);
        checkOutput("rst_alu_imm", 32'(bus.alu_immediate), 32'd0);
        checkOutput("rst_dmem_addr", bus.dmem_addr, 32'd0);
        checkOutput("rst_ra_addr", 32'(bus.ra_addr), 32'd0);
        checkOutput("rst_fetch_req", 32'(bus.imem_req), 32'd1);
`ifdef CU_INSTRET_COUNTER_EN
        checkOutput("rst_instret", instret, 32'd0);
`endif
    endtask

    // Runs one whole instruction from FETCH back to FETCH (or into HALT),
    // acting as memories/ALU and predicting every output along the way.
    task automatic applyStimulus(input logic [31:0] instr, input int fetchWait,
                                 input logic [31:0] aluRes, input logic [3:0] cmp,
                                 input logic [31:0] regA, input int memWait,
                                 input logic [31:0] rdata, input bit resetInMem);
        logic [4:0]  opc;
        logic [2:0]  rd;
        logic [2:0]  rn;
        logic [19:0] imm;
        logic        mode;
        logic [4:0]  expOp;
        logic        taken;
        int          kind;

        opc  = instr[31:27];
        mode = instr[26];
        rd   = instr[25:23];
        rn   = instr[22:20];
        imm  = instr[19:0];
        case (opc)
            5'b00000: kind = K_LDR;
            5'b00001: kind = K_STR;
            5'b00010, 5'b00011, 5'b00100, 5'b01000, 5'b01001, 5'b01010,
            5'b01011, 5'b01100, 5'b01101, 5'b10000: kind = K_ALU;
            5'b00101: kind = K_CMP;
            5'b10001, 5'b10010, 5'b10011, 5'b10100, 5'b10101: kind = K_BR;
            5'b11111: kind = K_HALT;
            default: kind = K_ILL;
        endcase
        expOp = (kind == K_CMP) ? 5'b00011 : ((kind == K_BR || kind == K_HALT) ? 5'b00100 : opc);

        checkOutput("fetch_req", 32'(bus.imem_req), 32'd1);
        checkOutput("fetch_addr", 32'(bus.imem_addr), 32'(mPc));
        repeat (fetchWait) begin
            bus.imem_valid = 1'b0;
            bus.dmem_ack   = 1'($urandom_range(0, 1));
            tick();
            checkOutput("fetch_hold", 32'(bus.imem_req), 32'd1);
        end
        bus.imem_valid = 1'b1;
        bus.imem_rdata = instr;
        tick();
        bus.imem_valid = 1'($urandom_range(0, 1));
        bus.imem_rdata = $urandom;
        bus.dmem_ack   = 1'($urandom_range(0, 1));
        checkOutput("decode_req", 32'(bus.imem_req), 32'd0);
        tick();

        if (kind != K_ILL) begin
            checkOutput("alu_opcode", 32'(bus.alu_opcode), 32'(expOp));
            checkOutput("alu_mode", 32'(bus.alu_addressing_mode), 32'(mode));
            checkOutput("alu_imm", 32'(bus.alu_immediate), 32'(imm));
            checkOutput("ra_addr", 32'(bus.ra_addr), 32'((kind == K_STR) ? rd : rn));
            if (mode) checkOutput("rb_addr", 32'(bus.rb_addr), 32'(imm[2:0]));
        end
        checkOutput("exec_rf_we", 32'(bus.rf_we), 32'd0);
        bus.alu_result = aluRes;
        bus.alu_cmp    = cmp;
        bus.reg_a_data = regA;
        tick();
        bus.alu_result = $urandom;
        bus.reg_a_data = $urandom;
        bus.imem_valid = 1'b0;

        if (kind == K_HALT || kind == K_ILL) begin
            checkOutput("halted", 32'(halted), 32'd1);
            checkOutput("illegal", 32'(illegal), 32'(kind == K_ILL));
            repeat (3) begin
                bus.imem_valid = 1'b1;
                tick();
                checkOutput("halt_imem_req", 32'(bus.imem_req), 32'd0);
                checkOutput("halt_dmem_req", 32'(bus.dmem_req), 32'd0);
                checkOutput("halt_rf_we", 32'(bus.rf_we), 32'd0);
            end
            bus.imem_valid = 1'b0;
            return;
        end

        case (kind)
            K_ALU: begin
                checkOutput("wb_rf_we", 32'(bus.rf_we), 32'd1);
                checkOutput("wb_waddr", 32'(bus.rf_waddr), 32'(rd));
                checkOutput("wb_wdata", bus.rf_wdata, aluRes);
                tick();
                checkOutput("wb_pulse_end", 32'(bus.rf_we), 32'd0);
                mPc = mPc + 1'b1;
            end
            K_LDR, K_STR: begin
                bus.dmem_ack = 1'b0;
                checkOutput("mem_req", 32'(bus.dmem_req), 32'd1);
                checkOutput("mem_we", 32'(bus.dmem_we), 32'(kind == K_STR));
                checkOutput("mem_addr", bus.dmem_addr, aluRes);
                if (kind == K_STR) checkOutput("mem_wdata", bus.dmem_wdata, regA);
                if (resetInMem) begin
                    rst = 1'b1;
                    #1;
                    checkOutput("rst_mem_req_drop", 32'(bus.dmem_req), 32'd0);
                    @(posedge clk);
                    #1;
                    rst          = 1'b0;
                    bus.dmem_ack = 1'b1;
                    bus.dmem_rdata = rdata;
                    #1;
                    mPc      = RST_PC;
                    mFlags   = 4'd0;
                    mInstret = 32'd0;
                    checkOutput("rst_mem_pc", 32'(pc), 32'(mPc));
                    checkOutput("rst_mem_dreq", 32'(bus.dmem_req), 32'd0);
                    tick();
                    checkOutput("late_ack_rf_we", 32'(bus.rf_we), 32'd0);
                    checkOutput("late_ack_dreq", 32'(bus.dmem_req), 32'd0);
                    checkOutput("late_ack_fetch", 32'(bus.imem_req), 32'd1);
                    bus.dmem_ack = 1'b0;
                    return;
                end
                repeat (memWait) begin
                    tick();
                    checkOutput("mem_hold_req", 32'(bus.dmem_req), 32'd1);
                    checkOutput("mem_hold_addr", bus.dmem_addr, aluRes);
                    checkOutput("mem_rf_we", 32'(bus.rf_we), 32'd0);
                end
                bus.dmem_ack   = 1'b1;
                bus.dmem_rdata = rdata;
                tick();
                bus.dmem_ack = 1'b0;
                checkOutput("mem_done_req", 32'(bus.dmem_req), 32'd0);
                if (kind == K_LDR) begin
                    checkOutput("ld_rf_we", 32'(bus.rf_we), 32'd1);
                    checkOutput("ld_waddr", 32'(bus.rf_waddr), 32'(rd));
                    checkOutput("ld_wdata", bus.rf_wdata, rdata);
                    tick();
                end
                checkOutput("mem_post_rf_we", 32'(bus.rf_we), 32'd0);
                mPc = mPc + 1'b1;
            end
            K_CMP: begin
                mFlags = cmp;
                mPc    = mPc + 1'b1;
            end
            default: begin
                case (opc)
                    5'b10001: taken = 1'b1;
                    5'b10010: taken = mFlags[0];
                    5'b10011: taken = mFlags[1];
                    5'b10100: taken = mFlags[3];
                    default:  taken = mFlags[2];
                endcase
                mPc = taken ? imm : mPc + 1'b1;
            end
        endcase
        mInstret = mInstret + 1;
        checkOutput("next_pc", 32'(pc), 32'(mPc));
        checkOutput("next_fetch", 32'(bus.imem_req), 32'd1);
`ifdef CU_INSTRET_COUNTER_EN
        checkOutput("instret", instret, mInstret);
`endif
    endtask

    initial begin
        logic [4:0]  op;
        logic [31:0] w;
        int          sel;

        bus.imem_valid = 1'b0;
        bus.imem_rdata = '0;
        bus.reg_a_data = '0;
        bus.alu_result = '0;
        bus.alu_cmp    = '0;
        bus.dmem_ack   = 1'b0;
        bus.dmem_rdata = '0;
        doReset();

        applyStimulus(32'h20800005, 0, 32'd5, 4'h0, 32'h0, 0, 32'h0, 1'b0);
        applyStimulus(32'h90000040, 0, 32'h0, 4'hF, 32'h0, 0, 32'h0, 1'b0);
        applyStimulus(32'h28100005, 1, 32'h0, 4'b0001, 32'h0, 0, 32'h0, 1'b0);
        applyStimulus(32'h90000040, 0, 32'h0, 4'b1110, 32'h0, 0, 32'h0, 1'b0);
        applyStimulus(32'h28100005, 0, 32'h0, 4'b1010, 32'h0, 0, 32'h0, 1'b0);
        applyStimulus(32'h90000040, 0, 32'h0, 4'b0001, 32'h0, 0, 32'h0, 1'b0);
        applyStimulus(32'h09000100, 2, 32'h100, 4'h0, 32'hCAFEF00D, 2, 32'h0, 1'b0);
        applyStimulus(32'h01800008, 0, 32'h8, 4'h0, 32'h12345678, 0, 32'hDEADBEEF, 1'b0);
        applyStimulus(32'h880FFFFF, 0, 32'h0, 4'h0, 32'h0, 0, 32'h0, 1'b0);
        applyStimulus(32'h20800007, 0, 32'd7, 4'h0, 32'h0, 0, 32'h0, 1'b0);
        applyStimulus(32'h01800008, 0, 32'h8, 4'h0, 32'h0, 3, 32'h55AA55AA, 1'b1);
        applyStimulus(32'hC0000000, 0, 32'h0, 4'h0, 32'h0, 0, 32'h0, 1'b0);
        doReset();

        for (int n = 0; n < 80; n++) begin
            sel = $urandom_range(0, 19);
            if (sel < 18) op = legalOps[sel];
            else if (sel == 18) op = 5'b11111;
            else op = illegalOps[$urandom_range(0, 12)];
            w = $urandom;
            w[31:27] = op;
            applyStimulus(w, $urandom_range(0, 2), $urandom, 4'($urandom_range(0, 15)),
                          $urandom, $urandom_range(0, 3), $urandom, 1'b0);
            if (sel >= 18) doReset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
